// File: rtl/counter_timer_ctrl.sv
// Programmable interval timer: command port, clock prescaler, terminal-count detection,
// one-shot or auto-reload operation, and sticky done/overrun status.
module counter_timer_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [WIDTH-1:0]      cfg_period,
   input  logic [PRESCALE_W-1:0] cfg_div,
   input  logic                  cfg_reload,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  paused,
   output logic                  tc_pulse,
   output logic                  done,
   output logic                  overrun
);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StHold} state_e;

   localparam logic [2:0] OpStart  = 3'd0;
   localparam logic [2:0] OpStop   = 3'd1;
   localparam logic [2:0] OpPause  = 3'd2;
   localparam logic [2:0] OpResume = 3'd3;
   localparam logic [2:0] OpClear  = 3'd4;
   localparam logic [2:0] OpAck    = 3'd5;

   localparam logic [WIDTH-1:0]      CountOne = WIDTH'(1);
   localparam logic [PRESCALE_W-1:0] PrescOne = PRESCALE_W'(1);

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]      period_q, period_d;
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic                  reload_q, reload_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;
   logic                  tc_pulse_q, tc_pulse_d;
   logic                  cmd_ready_q, cmd_ready_d;

   logic accept;
   logic is_ack;
   logic run_en;
   logic tick;
   logic tc;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      presc_d     = presc_q;
      period_d    = period_q;
      div_d       = div_q;
      reload_d    = reload_q;
      done_d      = done_q;
      overrun_d   = overrun_q;
      tc_pulse_d  = 1'b0;

      accept      = cmd_valid && cmd_ready_q;
      cmd_ready_d = !accept;
      is_ack      = accept && (cmd_op == OpAck);
      // Any accepted command other than ACK suspends counting on its edge, discarding a tick.
      run_en      = (state_q == StRun) && (!accept || is_ack);
      tick        = run_en && (presc_q == div_q);
      tc          = tick && (count_q == period_q);

      if (run_en) begin
         if (tick) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PrescOne;
         end
         if (tick && !tc) begin
            count_d = count_q + CountOne;
         end
      end

      if (accept) begin
         case (cmd_op)
            OpStart: begin
               period_d  = cfg_period;
               div_d     = cfg_div;
               reload_d  = cfg_reload;
               count_d   = '0;
               presc_d   = '0;
               done_d    = 1'b0;
               overrun_d = 1'b0;
               state_d   = StRun;
            end
            OpStop: begin
               state_d = StIdle;
            end
            OpPause: begin
               if (state_q == StRun) begin
                  state_d = StPause;
               end
            end
            OpResume: begin
               if (state_q == StPause) begin
                  state_d = StRun;
               end
            end
            OpClear: begin
               state_d   = StIdle;
               count_d   = '0;
               presc_d   = '0;
               done_d    = 1'b0;
               overrun_d = 1'b0;
            end
            OpAck: begin
               done_d    = 1'b0;
               overrun_d = 1'b0;
            end
            default: begin
            end
         endcase
      end

      // Evaluated after ACK so an ACK on the TC edge leaves done set but overrun clear.
      if (tc) begin
         overrun_d  = overrun_d | done_d;
         done_d     = 1'b1;
         tc_pulse_d = 1'b1;
         if (reload_q) begin
            count_d = '0;
         end else begin
            count_d = period_q;
            state_d = StHold;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= StIdle;
         count_q     <= '0;
         presc_q     <= '0;
         period_q    <= '0;
         div_q       <= '0;
         reload_q    <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         tc_pulse_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         presc_q     <= presc_d;
         period_q    <= period_d;
         div_q       <= div_d;
         reload_q    <= reload_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         tc_pulse_q  <= tc_pulse_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign count     = count_q;
   assign busy      = (state_q == StRun) || (state_q == StPause);
   assign paused    = (state_q == StPause);
   assign tc_pulse  = tc_pulse_q;
   assign done      = done_q;
   assign overrun   = overrun_q;

endmodule
